// File: rtl/rv32a_pkg.sv
// Shared definitions for the RV32A atomic sequencer.
// Holds the funct5 codes, the FSM state encoding and the legal-funct5 check.
package rv32a_pkg;

    localparam logic [4:0] AMO_ADD  = 5'h00;
    localparam logic [4:0] AMO_SWAP = 5'h01;
    localparam logic [4:0] LR       = 5'h02;
    localparam logic [4:0] SC       = 5'h03;
    localparam logic [4:0] AMO_XOR  = 5'h04;
    localparam logic [4:0] AMO_OR   = 5'h08;
    localparam logic [4:0] AMO_AND  = 5'h0C;
    localparam logic [4:0] AMO_MIN  = 5'h10;
    localparam logic [4:0] AMO_MAX  = 5'h14;
    localparam logic [4:0] AMO_MINU = 5'h18;
    localparam logic [4:0] AMO_MAXU = 5'h1C;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        WRITE,
        RESP
    } state_t;

    function automatic logic is_legal_f5(input logic [4:0] f);
        case (f)
            AMO_ADD, AMO_SWAP, LR, SC, AMO_XOR, AMO_OR, AMO_AND,
            AMO_MIN, AMO_MAX, AMO_MINU, AMO_MAXU: return 1'b1;
            default:                              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rv32a_amo_calc.sv
// Combinational AMO new-value computation: (funct5, old word, rs2) -> word to store.
// MIN/MAX keep the old value when the operands compare equal.
module rv32a_amo_calc
    import rv32a_pkg::*;
(
    input  logic [4:0]  func5,
    input  logic [31:0] old,
    input  logic [31:0] rs2,
    output logic [31:0] result
);

    logic signed [31:0] old_s;
    logic signed [31:0] rs2_s;
    logic               lt_s;
    logic               gt_s;
    logic               lt_u;
    logic               gt_u;

    assign old_s = old;
    assign rs2_s = rs2;
    assign lt_s  = rs2_s < old_s;
    assign gt_s  = rs2_s > old_s;
    assign lt_u  = rs2 < old;
    assign gt_u  = rs2 > old;

    always_comb begin
        result = rs2;
        case (func5)
            AMO_SWAP: result = rs2;
            AMO_ADD:  result = old + rs2;
            AMO_XOR:  result = old ^ rs2;
            AMO_AND:  result = old & rs2;
            AMO_OR:   result = old | rs2;
            AMO_MIN:  result = lt_s ? rs2 : old;
            AMO_MAX:  result = gt_s ? rs2 : old;
            AMO_MINU: result = lt_u ? rs2 : old;
            AMO_MAXU: result = gt_u ? rs2 : old;
            default:  result = rs2;
        endcase
    end

endmodule

// File: rtl/rv32a_amo_sequencer.sv
// Memory-side sequencer for RV32A LR.W / SC.W / AMO*.W with LR/SC reservation tracking.
// Optional macro RV32A_MISALIGN_TRAP_EN: misaligned addresses respond with an error instead of being forced to the word.
module rv32a_amo_sequencer
    import rv32a_pkg::*;
#(
    parameter int RAM_LAT = 1,
    parameter int AW      = 8
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iREQ_VALID,
    output logic          oREQ_READY,
    input  logic [4:0]    iFUNC5,
    input  logic [31:0]   iADDR,
    input  logic [31:0]   iRS2_DATA,
    input  logic [4:0]    iRD,
    output logic          oRESP_VALID,
    input  logic          iRESP_READY,
    output logic [4:0]    oRESP_RD,
    output logic [31:0]   oRESP_DATA,
    output logic          oRESP_ERR,
    output logic          oRAM_CE,
    output logic          oRAM_RD,
    output logic          oRAM_WR,
    output logic [AW-1:0] oRAM_ADDR,
    input  logic [31:0]   iRAM_DATA,
    output logic [31:0]   oRAM_DATA
);

    localparam logic [1:0] LAST = 2'(RAM_LAT - 1);

    state_t        state;
    state_t        state_nxt;
    logic [1:0]    cnt;
    logic          resv_valid;
    logic [AW-1:0] resv_addr;

    logic [4:0]    func_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   rs2_q;
    logic [4:0]    rd_q;
    logic [31:0]   old_q;
    logic [31:0]   resp_q;
    logic          err_q;

    logic          accept;
    logic          legal;
    logic          misalign;
    logic          sc_hit;
    logic          wait_done;
    logic [AW-1:0] word_in;
    logic [31:0]   amo_new;
    logic [31:0]   wdata;

`ifdef RV32A_MISALIGN_TRAP_EN
    logic unused_addr;
    assign misalign    = |iADDR[1:0];
    assign unused_addr = ^iADDR[31:AW+2];
`else
    logic unused_addr;
    assign misalign    = 1'b0;
    assign unused_addr = ^{iADDR[31:AW+2], iADDR[1:0]};
`endif

    assign word_in   = iADDR[AW+1:2];
    assign legal     = is_legal_f5(iFUNC5);
    assign accept    = iREQ_VALID && (state == IDLE);
    assign sc_hit    = resv_valid && (resv_addr == word_in);
    assign wait_done = (state == WAIT) && (cnt == LAST);

    rv32a_amo_calc u_calc (
        .func5  (func_q),
        .old    (old_q),
        .rs2    (rs2_q),
        .result (amo_new)
    );

    // SC stores rs2 untouched; every other write is an AMO result.
    assign wdata = (func_q == SC) ? rs2_q : amo_new;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state      <= IDLE;
            cnt        <= 2'd0;
            resv_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= ((state == WAIT) && (cnt != LAST)) ? cnt + 2'd1 : 2'd0;
            if (accept && legal && !misalign && (iFUNC5 == SC))
                resv_valid <= 1'b0;
            if (wait_done && (func_q == LR))
                resv_valid <= 1'b1;
            if ((state == WRITE) && (addr_q == resv_addr))
                resv_valid <= 1'b0;
        end
    end

    // Datapath registers carry no reset; every output they feed is gated by state.
    always_ff @(posedge iCLK) begin
        if (accept) begin
            func_q <= iFUNC5;
            addr_q <= word_in;
            rs2_q  <= iRS2_DATA;
            rd_q   <= iRD;
            err_q  <= !legal || misalign;
            resp_q <= (legal && !misalign && (iFUNC5 == SC) && !sc_hit) ? 32'd1 : 32'd0;
        end
        if (wait_done) begin
            old_q  <= iRAM_DATA;
            resp_q <= iRAM_DATA;
            if (func_q == LR)
                resv_addr <= addr_q;
        end
    end

    always_comb begin
        state_nxt   = state;
        oREQ_READY  = 1'b0;
        oRESP_VALID = 1'b0;
        oRESP_ERR   = 1'b0;
        oRESP_RD    = 5'd0;
        oRESP_DATA  = 32'd0;
        oRAM_CE     = 1'b0;
        oRAM_RD     = 1'b0;
        oRAM_WR     = 1'b0;
        oRAM_ADDR   = '0;
        oRAM_DATA   = 32'd0;
        case (state)
            IDLE: begin
                oREQ_READY = 1'b1;
                if (iREQ_VALID) begin
                    if (!legal || misalign)
                        state_nxt = RESP;
                    else if (iFUNC5 == SC)
                        state_nxt = sc_hit ? WRITE : RESP;
                    else
                        state_nxt = READ;
                end
            end
            READ: begin
                oRAM_CE   = 1'b1;
                oRAM_RD   = 1'b1;
                oRAM_ADDR = addr_q;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (cnt == LAST)
                    state_nxt = (func_q == LR) ? RESP : WRITE;
            end
            WRITE: begin
                oRAM_CE   = 1'b1;
                oRAM_WR   = 1'b1;
                oRAM_ADDR = addr_q;
                oRAM_DATA = wdata;
                state_nxt = RESP;
            end
            RESP: begin
                oRESP_VALID = 1'b1;
                oRESP_ERR   = err_q;
                oRESP_RD    = rd_q;
                oRESP_DATA  = resp_q;
                if (iRESP_READY)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
